// File: rtl/byte_capture_fifo.sv
// byte_capture_fifo: synchronous FIFO with a registered read port, count-derived
// full/empty status and sticky overflow/underflow flags.
module byte_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("byte_capture_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             rd_accept;
    logic             wr_accept;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign rd_accept = rd_en && !empty;
    // A read on the same edge frees a slot, so a write into a full FIFO still lands.
    assign wr_accept = wr_en && (!full || rd_accept);

    // Storage is never reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // out keeps the last popped word until the next accepted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_accept;
            if (rd_accept) begin
                out <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_accept) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_capture_fifo.sv
// tb_byte_capture_fifo: scoreboard bench for byte_capture_fifo (WIDTH=8, DEPTH=4);
// a queue model predicts each pop and the sticky flags.
module tb_byte_capture_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] out;
    logic       out_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    byte_capture_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in(in),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .out(out),
        .out_valid(out_valid),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic       m_over;
    logic       m_under;
    logic       exp_valid;
    logic [7:0] m_last;
    int         tests_run;
    int         tests_failed;

    task automatic do_reset(input logic w, input logic r);
        rst_n = 1'b0;
        wr_en = w;
        rd_en = r;
        in    = 8'h99;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_q.delete();
        exp_q.delete();
        m_over    = 1'b0;
        m_under   = 1'b0;
        m_last    = 8'h00;
        exp_valid = 1'b0;
    endtask

    // Predicts the edge, pushes the expected pop, then drives the DUT through it.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        logic rd_ok;
        logic wr_ok;
        rd_ok = r && (model_q.size() != 0);
        wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        if (w && !wr_ok) m_over = 1'b1;
        if (r && !rd_ok) m_under = 1'b1;
        exp_valid = rd_ok;
        wr_en = w;
        rd_en = r;
        in    = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (exp_valid && exp_q.size() != 0) m_last = exp_q.pop_front();
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        tests_run++;
        if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_status: got empty=%b full=%b expected empty=1 full=0", empty, full); end
        tests_run++;
        if (out !== 8'h00 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out: got out=%h valid=%b expected 00/0", out, out_valid); end
        tests_run++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got ovf=%b unf=%b expected 0/0", overflow, underflow); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] vals [4];
        vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, vals[i]);
            tests_run++;
            if (count !== 3'(i + 1)) begin tests_failed++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
        end
        tests_run++;
        if (full !== 1'b1 || empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_full: got full=%b empty=%b expected 1/0", full, empty); end
        cycle(1'b1, 1'b0, 8'hE5);
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_set: got %b expected 1", overflow); end
        tests_run++;
        if (count !== 3'd4 || full !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_count: got %0d full=%b expected 4/1", count, full); end
    endtask

    task automatic test_drain_underflow();
        logic [7:0] vals [4];
        vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            tests_run++;
            if (out_valid !== 1'b1 || out !== vals[i]) begin tests_failed++; $display("[TB] FAIL drain_pop[%0d]: got %h valid=%b expected %h valid=1", i, out, out_valid, vals[i]); end
        end
        cycle(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (out_valid !== 1'b0 || out !== 8'hD4) begin tests_failed++; $display("[TB] FAIL drain_hold: got %h valid=%b expected d4 valid=0", out, out_valid); end
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0) begin tests_failed++; $display("[TB] FAIL drain_empty: got empty=%b count=%0d expected 1/0", empty, count); end
        tests_run++;
        if (underflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL underflow_early: got %b expected 0", underflow); end
        cycle(1'b0, 1'b1, 8'h00);
        tests_run++;
        if (underflow !== 1'b1 || out_valid !== 1'b0 || out !== 8'hD4) begin tests_failed++; $display("[TB] FAIL underflow_read: got unf=%b valid=%b out=%h expected 1/0/d4", underflow, out_valid, out); end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(i + 1));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vals[i]);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            tests_run++;
            if (out_valid !== 1'b1 || out !== vals[i]) begin tests_failed++; $display("[TB] FAIL wrap_pop[%0d]: got %h valid=%b expected %h valid=1", i, out, out_valid, vals[i]); end
        end
        tests_run++;
        if (count !== 3'd0 || empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_count: got %0d empty=%b expected 0/1", count, empty); end
    endtask

    task automatic test_full_simul();
        logic [7:0] vals [4];
        vals = '{8'h02, 8'h03, 8'h04, 8'h5A};
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(i + 1));
        cycle(1'b1, 1'b1, 8'h5A);
        tests_run++;
        if (out_valid !== 1'b1 || out !== 8'h01) begin tests_failed++; $display("[TB] FAIL full_rw_out: got %h valid=%b expected 01 valid=1", out, out_valid); end
        tests_run++;
        if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_rw_state: got count=%0d full=%b ovf=%b expected 4/1/0", count, full, overflow); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            tests_run++;
            if (out !== vals[i]) begin tests_failed++; $display("[TB] FAIL full_rw_pop[%0d]: got %h expected %h", i, out, vals[i]); end
        end
    endtask

    task automatic test_empty_simul();
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h77);
        tests_run++;
        if (count !== 3'd1 || out_valid !== 1'b0 || underflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_rw: got count=%0d valid=%b unf=%b expected 1/0/1", count, out_valid, underflow); end
        cycle(1'b0, 1'b1, 8'h00);
        tests_run++;
        if (out_valid !== 1'b1 || out !== 8'h77) begin tests_failed++; $display("[TB] FAIL empty_rw_pop: got %h valid=%b expected 77 valid=1", out, out_valid); end
    endtask

    task automatic test_reset_midstream();
        do_reset(1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h40 + 8'(i));
        cycle(1'b0, 1'b1, 8'h00);
        tests_run++;
        if (count !== 3'd3 || overflow !== 1'b1 || underflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset: got count=%0d ovf=%b unf=%b expected 3/1/1", count, overflow, underflow); end
        do_reset(1'b1, 1'b1);
        tests_run++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_count: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
        tests_run++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || out !== 8'h00 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_out: got ovf=%b unf=%b out=%h valid=%b expected 0/0/00/0", overflow, underflow, out, out_valid); end
        cycle(1'b1, 1'b0, 8'h3C);
        cycle(1'b0, 1'b1, 8'h00);
        tests_run++;
        if (out_valid !== 1'b1 || out !== 8'h3C || underflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL first_after_reset: got %h valid=%b unf=%b expected 3c/1/0", out, out_valid, underflow); end
    endtask

    task automatic test_random();
        logic       w;
        logic       r;
        logic [7:0] d;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 99) < ((i % 100) < 50 ? 70 : 30));
            r = ($urandom_range(0, 99) < 50);
            d = 8'($urandom);
            cycle(w, r, d);
            tests_run++;
            if (out_valid !== exp_valid || out !== m_last) begin tests_failed++; $display("[TB] FAIL rand_out[%0d]: got %h valid=%b expected %h valid=%b", i, out, out_valid, m_last, exp_valid); end
            tests_run++;
            if (count !== 3'(model_q.size()) || full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
                tests_failed++;
                $display("[TB] FAIL rand_count[%0d]: got count=%0d full=%b empty=%b expected count=%0d", i, count, full, empty, model_q.size());
            end
            tests_run++;
            if (overflow !== m_over || underflow !== m_under) begin tests_failed++; $display("[TB] FAIL rand_flags[%0d]: got ovf=%b unf=%b expected %b/%b", i, overflow, underflow, m_over, m_under); end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        in    = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_full_simul();
        test_empty_simul();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/byte_capture_fifo.md
BYTE_CAPTURE_FIFO -- requirements
Module: byte_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of storage entries; the value SHALL be a power of two and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in  input  WIDTH  SHALL carry the byte presented by the upstream driver.
REQ-006 wr_en  input  1  SHALL request capture of in on this edge.
REQ-007 rd_en  input  1  SHALL request that the oldest stored word be popped to out.
REQ-008 out  output  WIDTH  SHALL be the registered read data.
REQ-009 out_valid  output  1  SHALL pulse high for one cycle when out holds newly popped data.
REQ-010 full  output  1  SHALL be high when count equals DEPTH.
REQ-011 empty  output  1  SHALL be high when count equals 0.
REQ-012 count  output  log2(DEPTH)+1  SHALL give the number of stored words, from 0 to DEPTH.
REQ-013 overflow  output  1  SHALL be a sticky flag set by any dropped write.
REQ-014 underflow  output  1  SHALL be a sticky flag set by any ignored read.

Function
REQ-015 A write SHALL be accepted when wr_en=1 and (full=0 or an accepted read occurs in the same cycle); in[WIDTH-1:0] SHALL be stored at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-016 A read SHALL be accepted when rd_en=1 and empty=0; on the next edge, out SHALL take mem[rd_ptr], out_valid SHALL go to 1 for one cycle, and rd_ptr SHALL increment modulo DEPTH.
REQ-017 Read latency SHALL be 1 cycle, from the edge where rd_en is sampled to out/out_valid being valid.
REQ-018 Data order SHALL be strictly first-in first-out, including across pointer wrap-around from DEPTH-1 to 0.
REQ-019 count SHALL change as follows: +1 for an accepted write alone, -1 for an accepted read alone, and no change when both are accepted or when neither is accepted.
REQ-020 Write and read in the same cycle while full: both SHALL be accepted, count SHALL stay at DEPTH, and full SHALL stay at 1.
REQ-021 Write and read in the same cycle while empty: the write SHALL be accepted, the read SHALL be ignored, underflow SHALL be set, and count SHALL become 1.
REQ-022 Write while full without a read: the word SHALL be dropped, the storage and pointers SHALL be unchanged, and overflow SHALL be set.
REQ-023 Read while empty: it SHALL be ignored; out SHALL hold its previous value, out_valid SHALL be 0, and underflow SHALL be set.
REQ-024 out SHALL hold its last popped value whenever out_valid=0.
REQ-025 full and empty SHALL be registered, or derived from registered count only; neither SHALL depend combinationally on wr_en or rd_en.
REQ-026 overflow and underflow SHALL clear only on reset.

Reset
REQ-027 While rst_n=0 at a clock edge, the next state SHALL be: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out=0, out_valid=0, overflow=0, underflow=0.
REQ-028 Reset SHALL take priority over simultaneous wr_en and rd_en; any in-flight operation SHALL be discarded.
REQ-029 Storage array contents SHALL NOT require reset and SHALL never be observable before being written.
REQ-030 The first accepted operation SHALL be possible on the first edge where rst_n=1.

Verification
REQ-031 Reset, then write 8'hA1, 8'hB2, 8'hC3, 8'hD4 -> full=1, count=4; a fifth write of 8'hE5 -> dropped, overflow=1, count=4.
REQ-032 From full, 4 reads -> out sequence A1, B2, C3, D4, each with a one-cycle out_valid pulse; afterwards empty=1; a further read -> underflow=1, out stays D4.
REQ-033 Wrap-around: write 3, read 3, then write 8'h11, 8'h22, 8'h33 and read 3 -> out 11, 22, 33 in order, count returns to 0.
REQ-034 While full, wr_en=rd_en=1 with in=8'h5A -> out=oldest word, count stays 4, overflow not set; 8'h5A is later read out in 4th position.
REQ-035 While empty, wr_en=rd_en=1 with in=8'h77 -> count=1, out_valid=0, underflow=1; the next read returns 8'h77.
REQ-036 Assert rst_n=0 for 1 cycle with count=3 and wr_en=1 -> count=0, empty=1, flags=0, out=0; the pending write is lost.
